// File: rtl/led_pattern_sequencer_if.sv
// Button/LED bundle between the board pins and the pattern sequencer.
interface led_pattern_sequencer_if #(
  parameter int unsigned LED_W = 4
);
  logic             BTNC;
  logic             BTND;
  logic [LED_W-1:0] LED;
  logic [1:0]       MODE;
  logic             STEP_PULSE;

  // Board side: drives the raw buttons, observes the LEDs
  modport master (
    output BTNC,
    output BTND,
    input  LED,
    input  MODE,
    input  STEP_PULSE
  );

  // Sequencer side
  modport slave (
    input  BTNC,
    input  BTND,
    output LED,
    output MODE,
    output STEP_PULSE
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: debounced step/mode buttons, four pattern modes,
// optional prescaler that auto-steps the pattern.
module led_pattern_sequencer #(
  parameter int unsigned LED_W           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AUTO_DIV        = 0
) (
  input logic                    CLK100MHZ,
  input logic                    BTNU,
  led_pattern_sequencer_if.slave bus
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned PreW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'((AUTO_DIV > 0) ? AUTO_DIV - 1 : 0);

  typedef enum logic [1:0] {
    ModeUp      = 2'd0,
    ModeDown    = 2'd1,
    ModeRing    = 2'd2,
    ModeJohnson = 2'd3
  } mode_t;

  // Index 0 = step button (BTNC), index 1 = mode button (BTND)
  logic [1:0]      w_raw;
  logic [1:0]      r_s1;
  logic [1:0]      r_s2;
  logic [1:0]      r_st;
  logic [1:0]      r_st_d;
  logic [CntW-1:0] r_cnt [2];
  logic [PreW-1:0] r_presc;
  mode_t           r_mode;
  logic [LED_W-1:0] r_led;

  logic [1:0]       w_press;
  logic             w_mode_evt;
  logic             w_tick;
  logic             w_step;
  mode_t            w_mode_next;
  logic [LED_W-1:0] w_led_step;
  logic [LED_W-1:0] w_seed_next;

  assign w_raw = {bus.BTND, bus.BTNC};

  // Synchronise both buttons and accept a change only after it has been stable long enough
  always_ff @(posedge CLK100MHZ) begin
    if (BTNU) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_st   <= '0;
      r_st_d <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_st_d <= r_st;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_st[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntMax) begin
          r_st[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only accepted rising edges produce events; releases are ignored
  assign w_press    = r_st & ~r_st_d;
  assign w_mode_evt = w_press[1];
  assign w_tick     = (AUTO_DIV > 0) && (r_presc == PreMax);
  assign w_step     = w_press[0] | w_tick;

  // Auto-step prescaler, restarted by a mode change so the new pattern gets a full period
  always_ff @(posedge CLK100MHZ) begin
    if (BTNU || w_mode_evt) begin
      r_presc <= '0;
    end else if (AUTO_DIV > 0) begin
      r_presc <= (r_presc == PreMax) ? '0 : r_presc + 1'b1;
    end
  end

  // Step rule of the current mode and seed of the following mode
  always_comb begin
    w_mode_next = mode_t'(r_mode + 2'd1);
    w_led_step  = r_led;
    w_seed_next = '0;
    unique case (r_mode)
      ModeUp:      w_led_step = r_led + 1'b1;
      ModeDown:    w_led_step = r_led - 1'b1;
      ModeRing:    w_led_step = {r_led[LED_W-2:0], r_led[LED_W-1]};
      ModeJohnson: w_led_step = {r_led[LED_W-2:0], ~r_led[LED_W-1]};
      default:     w_led_step = r_led;
    endcase
    unique case (w_mode_next)
      ModeUp:      w_seed_next = '0;
      ModeDown:    w_seed_next = '1;
      ModeRing:    w_seed_next = LED_W'(1);
      ModeJohnson: w_seed_next = '0;
      default:     w_seed_next = '0;
    endcase
  end

  // Mode/pattern state; a mode change wins over a coincident step
  always_ff @(posedge CLK100MHZ) begin
    if (BTNU) begin
      r_mode <= ModeUp;
      r_led  <= '0;
    end else if (w_mode_evt) begin
      r_mode <= w_mode_next;
      r_led  <= w_seed_next;
    end else if (w_step) begin
      r_led  <= w_led_step;
    end
  end

  assign bus.LED        = r_led;
  assign bus.MODE       = r_mode;
  assign bus.STEP_PULSE = w_step & ~w_mode_evt;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised scoreboard bench for led_pattern_sequencer plus an auto-step instance.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

  logic clk = 1'b0;
  logic btnu = 1'b1;
  always #400 clk = ~clk;

  led_pattern_sequencer_if #(.LED_W(4)) bus_if ();
  led_pattern_sequencer_if #(.LED_W(4)) auto_if ();

  led_pattern_sequencer #(.LED_W(4), .DEBOUNCE_CYCLES(4), .AUTO_DIV(0)) u_dut (
    .CLK100MHZ (clk),
    .BTNU      (btnu),
    .bus       (bus_if)
  );

  led_pattern_sequencer #(.LED_W(4), .DEBOUNCE_CYCLES(4), .AUTO_DIV(5)) u_auto (
    .CLK100MHZ (clk),
    .BTNU      (btnu),
    .bus       (auto_if)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];
  bit skip = 1'b1;
  bit auto_arm = 1'b0;
  int exp_steps = 0;
  int seen_steps = 0;
  int m_mode = 0;
  int m_led = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference pattern rules written as plain arithmetic on a 4-bit value
  function automatic int step_f(input int m, input int l);
    case (m)
      0:       return (l + 1) % 16;
      1:       return (l + 15) % 16;
      2:       return (l * 2) % 16 + l / 8;
      default: return (l * 2) % 16 + ((l < 8) ? 1 : 0);
    endcase
  endfunction

  function automatic int seed_f(input int m);
    case (m)
      1:       return 15;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic apply(input bit c, input bit d);
    if (d) begin
      m_mode = (m_mode + 1) % 4;
      m_led  = seed_f(m_mode);
      sb.push_back({2'(m_mode), 4'(m_led)});
    end else if (c) begin
      m_led = step_f(m_mode, m_led);
      sb.push_back({2'(m_mode), 4'(m_led)});
      exp_steps++;
    end
  endtask

  task automatic press(input bit c, input bit d, input int hold);
    apply(c, d);
    @(negedge clk);
    bus_if.BTNC = c;
    bus_if.BTND = d;
    repeat (hold) @(negedge clk);
    bus_if.BTNC = 1'b0;
    bus_if.BTND = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic glitch(input bit c, input bit d, input int len);
    @(negedge clk);
    bus_if.BTNC = c;
    bus_if.BTND = d;
    repeat (len) @(negedge clk);
    bus_if.BTNC = 1'b0;
    bus_if.BTND = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    check("sb_empty_before_reset", sb.size(), 0);
    skip = 1'b1;
    @(negedge clk);
    btnu = 1'b1;
    @(negedge clk);
    check("reset_led", int'(bus_if.LED), 0);
    check("reset_mode", int'(bus_if.MODE), 0);
    check("reset_step", int'(bus_if.STEP_PULSE), 0);
    @(negedge clk);
    btnu = 1'b0;
    repeat (2) @(negedge clk);
    skip   = 1'b0;
    m_mode = 0;
    m_led  = 0;
  endtask

  // Monitor: every change of {MODE,LED} must match the next scoreboard entry
  initial begin
    logic [5:0] prev;
    logic [5:0] cur;
    logic [5:0] want;
    prev = '0;
    forever begin
      @(posedge clk);
      #100;
      cur = {bus_if.MODE, bus_if.LED};
      if (!skip) begin
        if (bus_if.STEP_PULSE) seen_steps++;
        if (cur != prev) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change got %h expected no change at %0t", cur, $time);
          end else begin
            want = sb.pop_front();
            if (cur !== want) begin
              errors++;
              $display("FAIL sb_state got %h expected %h at %0t", cur, want, $time);
            end
          end
        end
      end
      prev = cur;
    end
  end

  // Auto-step instance: LED counts up once every 5 cycles after reset
  initial begin
    int acnt;
    int aexp;
    acnt = 0;
    aexp = 0;
    forever begin
      @(posedge clk);
      #100;
      if (btnu) begin
        acnt = 0;
        aexp = 0;
      end else begin
        acnt++;
        if (acnt == 5) begin
          acnt = 0;
          aexp = (aexp + 1) % 16;
        end
      end
      if (auto_arm) check("auto_led", int'(auto_if.LED), aexp);
    end
  end

  initial begin
    int op;
    bus_if.BTNC  = 1'b0;
    bus_if.BTND  = 1'b0;
    auto_if.BTNC = 1'b0;
    auto_if.BTND = 1'b0;
    do_reset();
    auto_arm = 1'b1;

    // Exact latency of one held press
    apply(1'b1, 1'b0);
    @(negedge clk);
    bus_if.BTNC = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("latency_step", int'(bus_if.STEP_PULSE), (j == 5) ? 1 : 0);
      check("latency_led", int'(bus_if.LED), (j >= 6) ? 1 : 0);
      if (j == 9) bus_if.BTNC = 1'b0;
    end
    repeat (10) @(negedge clk);

    // Glitch ignored, then wrap after 16 presses total
    glitch(1'b1, 1'b0, 3);
    for (int i = 0; i < 15; i++) press(1'b1, 1'b0, 6);
    check("wrap_led", int'(bus_if.LED), 0);

    // Walk through every mode with a few steps each
    press(1'b0, 1'b1, 6);
    press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 6);
    check("johnson_led", int'(bus_if.LED), 4'b1110);
    press(1'b0, 1'b1, 6);
    check("mode_wrap", int'(bus_if.MODE), 0);

    // Coincident step and mode presses: only the mode change happens
    press(1'b1, 1'b1, 8);

    // Reset while the step button is held: one new press after reset
    apply(1'b1, 1'b0);
    @(negedge clk);
    bus_if.BTNC = 1'b1;
    repeat (10) @(negedge clk);
    do_reset();
    apply(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    bus_if.BTNC = 1'b0;
    repeat (10) @(negedge clk);

    // Randomised mix
    for (int i = 0; i < 50; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4)      press(1'b1, 1'b0, $urandom_range(5, 12));
      else if (op <= 6) press(1'b0, 1'b1, $urandom_range(5, 12));
      else if (op == 7) press(1'b1, 1'b1, $urandom_range(5, 12));
      else if (op == 8) begin
        if ($urandom_range(0, 1) == 1) glitch(1'b1, 1'b0, $urandom_range(1, 3));
        else glitch(1'b0, 1'b1, $urandom_range(1, 3));
      end else do_reset();
    end

    repeat (20) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("step_count", seen_steps, exp_steps);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
